timer_multi_core: RTL and testbench

//  N-channel timer core: one shared prescaler plus per-channel counters. Each channel

---
 rtl/timer_multi_pkg.sv | 28 ++
 rtl/timer_multi_if.sv | 27 ++
 rtl/timer_chan.sv | 128 ++++++++++++
 rtl/timer_multi_core.sv | 64 ++++++
 tb/tb_timer_multi_core.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_multi_pkg.sv
// Shared encodings for the multi-channel timer: channel modes and channel FSM states.
package timer_multi_pkg;

    typedef enum logic [1:0] {
        MODE_FREE     = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // The reserved encoding behaves exactly like free-running, so fold it here once.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'b01:   m = MODE_PERIODIC;
            2'b10:   m = MODE_ONESHOT;
            default: m = MODE_FREE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/timer_multi_if.sv
// Software-register-bank side of the timer: per-channel controls in, snapshots and status out.
interface timer_multi_if #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 64,
    parameter int PRESC_W = 16
);
    logic [PRESC_W-1:0]    presc_i;
    logic [N_CH-1:0]       en_i;
    logic [N_CH-1:0]       clr_i;
    logic [N_CH-1:0]       sample_i;
    logic [2*N_CH-1:0]     mode_i;
    logic [N_CH*CNT_W-1:0] cmp_i;
    logic [N_CH-1:0]       irq_ack_i;
    logic [N_CH*CNT_W-1:0] value_o;
    logic [N_CH-1:0]       irq_o;
    logic [N_CH-1:0]       done_o;

    modport master (
        output presc_i, en_i, clr_i, sample_i, mode_i, cmp_i, irq_ack_i,
        input  value_o, irq_o, done_o
    );

    modport slave (
        input  presc_i, en_i, clr_i, sample_i, mode_i, cmp_i, irq_ack_i,
        output value_o, irq_o, done_o
    );
endinterface

// File: rtl/timer_chan.sv
// One timer channel: IDLE/RUN/DONE FSM, counter with compare, snapshot and sticky IRQ.
module timer_chan
    import timer_multi_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cke_i,
    input  logic             tick_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             sample_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] cmp_i,
    input  logic             irq_ack_i,
    output logic [CNT_W-1:0] value_o,
    output logic             irq_o,
    output logic             done_o
);

    mode_e            w_mode;
    logic             w_active;
    logic             w_match;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_value;
    logic             r_irq;
    logic             r_done;
    state_e           r_state;

    assign w_mode   = decode_mode(mode_i);
    // The enable is honoured on the same edge that moves IDLE->RUN, so a channel
    // counts from the first edge at which en_i is seen high. DONE never counts.
    assign w_active = en_i & (r_state != ST_DONE);
    // A clear in the same cycle wins over a match.
    assign w_match  = tick_i & w_active & ~clr_i & (r_cnt == cmp_i);

    // Counter: clear > match (mode dependent) > increment on tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (cke_i) begin
            if (clr_i) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (w_match) begin
                case (w_mode)
                    MODE_PERIODIC: r_cnt <= {CNT_W{1'b0}};
                    MODE_ONESHOT:  r_cnt <= r_cnt;
                    default:       r_cnt <= r_cnt + CNT_W'(1);
                endcase
            end else if (tick_i && w_active) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Snapshot of the pre-edge count and sticky IRQ (set beats acknowledge).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_value <= {CNT_W{1'b0}};
            r_irq   <= 1'b0;
        end else if (cke_i) begin
            if (sample_i) begin
                r_value <= r_cnt;
            end else begin
                r_value <= r_value;
            end
            if (w_match) begin
                r_irq <= 1'b1;
            end else if (irq_ack_i) begin
                r_irq <= 1'b0;
            end else begin
                r_irq <= r_irq;
            end
        end else begin
            r_value <= r_value;
            r_irq   <= r_irq;
        end
    end

    // Channel FSM with registered done flag; DONE is only left through a clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else if (cke_i) begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_match && (w_mode == MODE_ONESHOT)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (en_i) begin
                        r_state <= ST_RUN;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (clr_i) begin
                        r_state <= en_i ? ST_RUN : ST_IDLE;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end else begin
            r_state <= r_state;
            r_done  <= r_done;
        end
    end

    assign value_o = r_value;
    assign irq_o   = r_irq;
    assign done_o  = r_done;

endmodule

// File: rtl/timer_multi_core.sv
// N-channel timer: one shared prescaler whose tick drives every channel.
module timer_multi_core
    import timer_multi_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 64,
    parameter int PRESC_W = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cke_i,
    timer_multi_if.slave  bus_if
);

    logic [PRESC_W-1:0]          r_pcnt;
    logic                        w_tick;
    logic [N_CH-1:0][CNT_W-1:0]  w_value;
    logic [N_CH-1:0]             w_irq;
    logic [N_CH-1:0]             w_done;

    // Tick only on exact equality: lowering the divisor below the running count
    // lets it wrap through the top of its range rather than firing early.
    assign w_tick = (r_pcnt == bus_if.presc_i);

    // Shared prescaler counting 0..presc_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pcnt <= {PRESC_W{1'b0}};
        end else if (cke_i) begin
            if (w_tick) begin
                r_pcnt <= {PRESC_W{1'b0}};
            end else begin
                r_pcnt <= r_pcnt + PRESC_W'(1);
            end
        end else begin
            r_pcnt <= r_pcnt;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        timer_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .cke_i     (cke_i),
            .tick_i    (w_tick),
            .en_i      (bus_if.en_i[g]),
            .clr_i     (bus_if.clr_i[g]),
            .sample_i  (bus_if.sample_i[g]),
            .mode_i    (bus_if.mode_i[2*g +: 2]),
            .cmp_i     (bus_if.cmp_i[g*CNT_W +: CNT_W]),
            .irq_ack_i (bus_if.irq_ack_i[g]),
            .value_o   (w_value[g]),
            .irq_o     (w_irq[g]),
            .done_o    (w_done[g])
        );
    end

    assign bus_if.value_o = w_value;
    assign bus_if.irq_o   = w_irq;
    assign bus_if.done_o  = w_done;

endmodule

// File: tb/tb_timer_multi_core.sv
// Scoreboard bench: stimulus queues expected values tagged with the cycle they are due,
// a negedge monitor pops and compares them. A second 8-bit instance covers counter wrap.
module tb_timer_multi_core;

    localparam int K_VAL   = 0;
    localparam int K_IRQ   = 1;
    localparam int K_DONE  = 2;
    localparam int K_VAL8  = 3;
    localparam int K_IRQ8  = 4;
    localparam int K_DONE8 = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cke = 1'b1;
    logic flush = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [63:0] act;

    typedef struct {
        string       name;
        int          kind;
        int          ch;
        logic [63:0] exp;
        int          at;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    timer_multi_if #(.N_CH(4), .CNT_W(64), .PRESC_W(16)) if64 ();
    timer_multi_if #(.N_CH(1), .CNT_W(8),  .PRESC_W(16)) if8 ();

    timer_multi_core #(.N_CH(4), .CNT_W(64), .PRESC_W(16)) u_dut64 (
        .clk_i  (clk),
        .rst_i  (rst),
        .cke_i  (cke),
        .bus_if (if64)
    );

    timer_multi_core #(.N_CH(1), .CNT_W(8), .PRESC_W(16)) u_dut8 (
        .clk_i  (clk),
        .rst_i  (rst),
        .cke_i  (cke),
        .bus_if (if8)
    );

    function automatic logic [63:0] actual(input int kind, input int ch);
        case (kind)
            K_VAL:   return if64.value_o[ch*64 +: 64];
            K_IRQ:   return {63'd0, if64.irq_o[ch]};
            K_DONE:  return {63'd0, if64.done_o[ch]};
            K_VAL8:  return {56'd0, if8.value_o[ch*8 +: 8]};
            K_IRQ8:  return {63'd0, if8.irq_o[ch]};
            K_DONE8: return {63'd0, if8.done_o[ch]};
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation that has come due; on flush, anything left is a failure.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                act = actual(sb[i].kind, sb[i].ch);
                n_tests++;
                if ((sb[i].at != cyc) || (act !== sb[i].exp)) begin
                    n_fail++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d, due %0d)",
                             sb[i].name, act, sb[i].exp, cyc, sb[i].at);
                end
                sb.delete(i);
            end
        end
        if (flush) begin
            while (sb.size() > 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: never checked, expected %0d", sb[0].name, sb[0].exp);
                sb.delete(0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int kind, input int ch,
                       input logic [63:0] e, input int dly);
        exp_t x;
        x.name = nm;
        x.kind = kind;
        x.ch   = ch;
        x.exp  = e;
        x.at   = cyc + dly;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cke = 1'b1;
        if64.presc_i = '0; if64.en_i = '0; if64.clr_i = '0; if64.sample_i = '0;
        if64.mode_i = '0; if64.cmp_i = '0; if64.irq_ack_i = '0;
        if8.presc_i = '0; if8.en_i = '0; if8.clr_i = '0; if8.sample_i = '0;
        if8.mode_i = '0; if8.cmp_i = '0; if8.irq_ack_i = '0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        for (int c = 0; c < 4; c++) begin
            chk("rst_value", K_VAL, c, 64'd0, 0);
            chk("rst_irq", K_IRQ, c, 64'd0, 0);
            chk("rst_done", K_DONE, c, 64'd0, 0);
        end
        chk("rst_value8", K_VAL8, 0, 64'd0, 0);

        // 1: presc=0 free-running, 1000 counting edges
        if64.cmp_i[63:0] = 64'hFFFF_FFFF;
        if64.en_i[0] = 1'b1;
        step(1000);
        if64.sample_i[0] = 1'b1;
        chk("t1_value_1000", K_VAL, 0, 64'd1000, 1);
        chk("t1_no_irq", K_IRQ, 0, 64'd0, 1);
        step(1);
        if64.sample_i[0] = 1'b0;

        // 2: presc=9, shared by ch0 and ch1
        do_reset();
        if64.presc_i = 16'd9;
        if64.cmp_i[63:0] = 64'hFFFF_FFFF;
        if64.cmp_i[127:64] = 64'hFFFF_FFFF;
        if64.en_i[1:0] = 2'b11;
        step(95);
        if64.sample_i[0] = 1'b1;
        chk("t2_value_at95", K_VAL, 0, 64'd9, 1);
        step(1);
        if64.sample_i[0] = 1'b0;
        step(4);
        if64.en_i[1:0] = 2'b00;
        if64.sample_i[1:0] = 2'b11;
        chk("t2_value_ch0", K_VAL, 0, 64'd10, 1);
        chk("t2_value_ch1", K_VAL, 1, 64'd10, 1);
        step(1);
        if64.sample_i[1:0] = 2'b00;

        // 3: periodic cmp=4 on ch2, snapshot every cycle
        do_reset();
        if64.mode_i[5:4] = 2'b01;
        if64.cmp_i[191:128] = 64'd4;
        if64.en_i[2] = 1'b1;
        if64.sample_i[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_seq", K_VAL, 2, 64'(k), 1);
            step(1);
        end
        chk("t3_irq_before", K_IRQ, 2, 64'd0, 0);
        chk("t3_seq4", K_VAL, 2, 64'd4, 1);
        chk("t3_irq_match", K_IRQ, 2, 64'd1, 1);
        step(1);
        if64.irq_ack_i[2] = 1'b1;
        chk("t3_wrap0", K_VAL, 2, 64'd0, 1);
        chk("t3_irq_acked", K_IRQ, 2, 64'd0, 1);
        step(1);
        if64.irq_ack_i[2] = 1'b0;
        step(3);
        chk("t3_irq_still0", K_IRQ, 2, 64'd0, 0);
        if64.irq_ack_i[2] = 1'b1;
        chk("t3_set_beats_ack", K_IRQ, 2, 64'd1, 1);
        chk("t3_seq4_again", K_VAL, 2, 64'd4, 1);
        step(1);
        if64.irq_ack_i[2] = 1'b0;
        chk("t3_wrap0_again", K_VAL, 2, 64'd0, 1);
        step(1);
        if64.sample_i[2] = 1'b0;

        // 4: one-shot cmp=7 on ch3
        do_reset();
        if64.mode_i[7:6] = 2'b10;
        if64.cmp_i[255:192] = 64'd7;
        if64.en_i[3] = 1'b1;
        step(7);
        chk("t4_done_before", K_DONE, 3, 64'd0, 0);
        chk("t4_irq_before", K_IRQ, 3, 64'd0, 0);
        chk("t4_done", K_DONE, 3, 64'd1, 1);
        chk("t4_irq", K_IRQ, 3, 64'd1, 1);
        step(3);
        if64.en_i[3] = 1'b0;
        step(1);
        if64.en_i[3] = 1'b1;
        step(1);
        if64.sample_i[3] = 1'b1;
        chk("t4_cnt_held", K_VAL, 3, 64'd7, 1);
        chk("t4_done_after_en_toggle", K_DONE, 3, 64'd1, 1);
        step(1);
        if64.sample_i[3] = 1'b0;
        if64.clr_i[3] = 1'b1;
        chk("t4_clr_done", K_DONE, 3, 64'd0, 1);
        chk("t4_irq_sticky", K_IRQ, 3, 64'd1, 1);
        step(1);
        if64.clr_i[3] = 1'b0;
        if64.sample_i[3] = 1'b1;
        chk("t4_cnt_cleared", K_VAL, 3, 64'd0, 1);
        step(1);
        chk("t4_running_again", K_VAL, 3, 64'd1, 1);
        step(1);
        if64.sample_i[3] = 1'b0;

        // 5: 8-bit counter, free-running cmp=255, wrap and clear-with-tick
        do_reset();
        if8.cmp_i = 8'hFF;
        if8.en_i[0] = 1'b1;
        step(255);
        chk("t5_irq_before", K_IRQ8, 0, 64'd0, 0);
        chk("t5_irq_at_255", K_IRQ8, 0, 64'd1, 1);
        step(1);
        if8.sample_i[0] = 1'b1;
        chk("t5_wrapped", K_VAL8, 0, 64'd0, 1);
        chk("t5_done_free", K_DONE8, 0, 64'd0, 1);
        step(1);
        if8.clr_i[0] = 1'b1;
        chk("t5_pre_clr", K_VAL8, 0, 64'd1, 1);
        step(1);
        if8.clr_i[0] = 1'b0;
        chk("t5_clr_beats_tick", K_VAL8, 0, 64'd0, 1);
        step(1);
        if8.sample_i[0] = 1'b0;

        // 6: clock-enable freeze, then reset with IRQ pending
        do_reset();
        if64.cmp_i[63:0] = 64'd5;
        if64.en_i[0] = 1'b1;
        step(5);
        chk("t6_irq_before", K_IRQ, 0, 64'd0, 0);
        chk("t6_irq_free_match", K_IRQ, 0, 64'd1, 1);
        step(5);
        cke = 1'b0;
        step(4);
        if64.sample_i[0] = 1'b1;
        chk("t6_sample_frozen", K_VAL, 0, 64'd0, 1);
        step(1);
        if64.sample_i[0] = 1'b0;
        step(15);
        cke = 1'b1;
        if64.sample_i[0] = 1'b1;
        chk("t6_cnt_unchanged", K_VAL, 0, 64'd10, 1);
        chk("t6_irq_kept", K_IRQ, 0, 64'd1, 1);
        step(1);
        if64.sample_i[0] = 1'b0;
        rst = 1'b1;
        chk("t6_rst_value", K_VAL, 0, 64'd0, 1);
        chk("t6_rst_irq", K_IRQ, 0, 64'd0, 1);
        chk("t6_rst_done", K_DONE, 0, 64'd0, 1);
        step(1);
        rst = 1'b0;

        flush = 1'b1;
        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
